wb_arbiter: RTL and testbench

- Writer-side companion to the register file: it owns the single write port (we/rd/dataIn).
- Merges two result sources into one registered write stream:
  - the main pipeline writeback, which is never back-pressured;
  - the multicycle mult/div unit (MDU), which uses a valid/ready handshake.
- MDU results that lose arbitration wait in a small in-order FIFO.
- A starvation counter requests a pipeline bubble so queued MDU results drain.

---
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Merges pipeline writeback and queued MDU results onto the single
//             registered register-file write port.
//  Revision : 1.0
// ============================================================================
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          p_valid,
    input  logic [ADDR_W-1:0]             p_rd,
    input  logic [DATA_W-1:0]             p_data,
    input  logic                          m_valid,
    output logic                          m_ready,
    input  logic [ADDR_W-1:0]             m_rd,
    input  logic [DATA_W-1:0]             m_data,
    output logic                          wb_we,
    output logic [ADDR_W-1:0]             wb_rd,
    output logic [DATA_W-1:0]             wb_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   pending_mask,
    output logic                          stall_req
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] c_DEPTH  = CNT_W'(FIFO_DEPTH);
    localparam logic [SW-1:0]    c_STARVE = SW'(STARVE_MAX);

    logic [ADDR_W-1:0]     r_rd_mem   [FIFO_DEPTH];
    logic [DATA_W-1:0]     r_data_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_vld;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic [SW-1:0]         r_starve;
    logic                  r_stall;
    logic                  r_wb_we;
    logic [ADDR_W-1:0]     r_wb_rd;
    logic [DATA_W-1:0]     r_wb_data;

    logic                  w_empty;
    logic                  w_accept;
    logic                  w_m_live;
    logic                  w_p_live;
    logic                  w_issue_p;
    logic                  w_issue_head;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [SW-1:0]         w_starve_next;
    logic [31:0]           w_pending;

    assign w_empty      = (r_count == '0);
    assign m_ready      = rst & (r_count < c_DEPTH);
    assign w_accept     = m_valid & m_ready;
    // Writes to $0 are dropped on both sources.
    assign w_m_live     = w_accept & (m_rd != '0);
    assign w_p_live     = p_valid & (p_rd != '0);

    assign w_issue_p    = w_p_live;
    assign w_issue_head = !w_p_live && !w_empty;
    assign w_bypass     = !w_p_live && w_empty && w_m_live;
    assign w_push       = w_m_live && !w_bypass;
    assign w_pop        = w_issue_head;

    always_comb begin
        w_starve_next = '0;
        if (!w_empty && w_issue_p) begin
            w_starve_next = (r_starve == c_STARVE) ? r_starve : r_starve + SW'(1);
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_vld[i]) begin
                w_pending[r_rd_mem[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_we   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_vld     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
        end else begin
            r_wb_we <= w_issue_p | w_issue_head | w_bypass;
            if (w_issue_p) begin
                r_wb_rd   <= p_rd;
                r_wb_data <= p_data;
            end else if (w_issue_head) begin
                r_wb_rd   <= r_rd_mem[r_rptr];
                r_wb_data <= r_data_mem[r_rptr];
            end else if (w_bypass) begin
                r_wb_rd   <= m_rd;
                r_wb_data <= m_data;
            end

            // Push and pop never address the same slot: pop needs a non-empty
            // queue and push is blocked when full.
            if (w_push) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            r_starve <= w_starve_next;
            r_stall  <= (w_starve_next == c_STARVE);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_wptr]   <= m_rd;
            r_data_mem[r_wptr] <= m_data;
        end
    end

    assign wb_we        = r_wb_we;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign fifo_count   = r_count;
    assign pending_mask = w_pending;
    assign stall_req    = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Purpose  : Directed self-checking bench for wb_arbiter.
//  Revision : 1.0
// ============================================================================
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        p_valid;
    logic [4:0]  p_rd;
    logic [31:0] p_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  fifo_count;
    logic [31:0] pending_mask;
    logic        stall_req;

    int checks = 0;
    int errors = 0;

    wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .p_valid      (p_valid),
        .p_rd         (p_rd),
        .p_data       (p_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_rd         (m_rd),
        .m_data       (m_data),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .fifo_count   (fifo_count),
        .pending_mask (pending_mask),
        .stall_req    (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, ".we"}, {31'd0, wb_we}, {31'd0, we});
        if (we) begin
            chk({tag, ".rd"}, {27'd0, wb_rd}, {27'd0, rd});
            chk({tag, ".data"}, wb_data, d);
        end
    endtask

    initial begin
        rst = 1'b0; p_valid = 1'b0; p_rd = '0; p_data = '0;
        m_valid = 1'b0; m_rd = '0; m_data = '0;

        // Reset state
        #12;
        chk_wb("rst", 1'b0, 5'd0, 32'd0);
        chk("rst.wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        chk("rst.count", {29'd0, fifo_count}, 32'd0);
        chk("rst.pending", pending_mask, 32'd0);
        chk("rst.stall", {31'd0, stall_req}, 32'd0);
        chk("rst.m_ready", {31'd0, m_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel.m_ready", {31'd0, m_ready}, 32'd1);

        // 1: single pipeline write, then idle with held address/data
        tick();
        p_valid = 1'b1; p_rd = 5'd5; p_data = 32'hDEADBEEF;
        tick();
        chk_wb("t1.issue", 1'b1, 5'd5, 32'hDEADBEEF);
        p_valid = 1'b0;
        tick();
        chk_wb("t1.idle", 1'b0, 5'd0, 32'd0);
        chk("t1.hold_rd", {27'd0, wb_rd}, 32'd5);
        chk("t1.hold_data", wb_data, 32'hDEADBEEF);

        // 2: bypass with empty queue
        m_valid = 1'b1; m_rd = 5'd9; m_data = 32'h11;
        tick();
        chk_wb("t2.bypass", 1'b1, 5'd9, 32'h11);
        chk("t2.count", {29'd0, fifo_count}, 32'd0);
        chk("t2.pending", pending_mask, 32'd0);
        m_valid = 1'b0;
        tick();
        chk_wb("t2.idle", 1'b0, 5'd0, 32'd0);

        // 3: simultaneous pipeline and MDU
        p_valid = 1'b1; p_rd = 5'd3; p_data = 32'hA;
        m_valid = 1'b1; m_rd = 5'd4; m_data = 32'hB;
        tick();
        chk_wb("t3.pipe", 1'b1, 5'd3, 32'hA);
        chk("t3.count1", {29'd0, fifo_count}, 32'd1);
        chk("t3.pending1", pending_mask, 32'h10);
        p_valid = 1'b0; m_valid = 1'b0;
        tick();
        chk_wb("t3.mdu", 1'b1, 5'd4, 32'hB);
        chk("t3.count0", {29'd0, fifo_count}, 32'd0);
        chk("t3.pending0", pending_mask, 32'd0);
        tick();
        chk_wb("t3.idle", 1'b0, 5'd0, 32'd0);

        // 4: pipeline hogs the port while MDU fills the queue
        p_valid = 1'b1; p_rd = 5'd7; p_data = 32'h77;
        m_valid = 1'b1;
        for (int r = 10; r <= 13; r++) begin
            m_rd = 5'(r); m_data = 32'h100 + 32'(r);
            tick();
            chk_wb("t4.pipe", 1'b1, 5'd7, 32'h77);
            chk("t4.count", {29'd0, fifo_count}, 32'(r - 9));
        end
        chk("t4.m_ready_full", {31'd0, m_ready}, 32'd0);
        chk("t4.pending_full", pending_mask, 32'h00003C00);
        m_rd = 5'd14; m_data = 32'h10E;
        for (int k = 0; k < 4; k++) tick();
        chk("t4.stall_pre", {31'd0, stall_req}, 32'd0);
        tick();
        chk("t4.stall_set", {31'd0, stall_req}, 32'd1);
        tick();
        chk("t4.stall_sat", {31'd0, stall_req}, 32'd1);
        chk("t4.count_hold", {29'd0, fifo_count}, 32'd4);
        p_valid = 1'b0;
        tick();
        chk_wb("t4.drain10", 1'b1, 5'd10, 32'h10A);
        chk("t4.stall_clr", {31'd0, stall_req}, 32'd0);
        chk("t4.pending3", pending_mask, 32'h00003800);
        chk("t4.m_ready_free", {31'd0, m_ready}, 32'd1);
        tick();
        chk_wb("t4.drain11", 1'b1, 5'd11, 32'h10B);
        chk("t4.count_pushpop", {29'd0, fifo_count}, 32'd3);
        chk("t4.pending14", pending_mask, 32'h00007000);
        m_valid = 1'b0;
        tick();
        chk_wb("t4.drain12", 1'b1, 5'd12, 32'h10C);
        tick();
        chk_wb("t4.drain13", 1'b1, 5'd13, 32'h10D);
        tick();
        chk_wb("t4.drain14", 1'b1, 5'd14, 32'h10E);
        chk("t4.count_end", {29'd0, fifo_count}, 32'd0);
        chk("t4.pending_end", pending_mask, 32'd0);
        tick();
        chk_wb("t4.idle", 1'b0, 5'd0, 32'd0);

        // 5: both sources targeting $0
        p_valid = 1'b1; p_rd = 5'd0; p_data = 32'h55;
        m_valid = 1'b1; m_rd = 5'd0; m_data = 32'h5;
        tick();
        chk_wb("t5.r0", 1'b0, 5'd0, 32'd0);
        chk("t5.count", {29'd0, fifo_count}, 32'd0);
        chk("t5.pending", pending_mask, 32'd0);
        p_valid = 1'b0; m_valid = 1'b0;
        tick();
        chk_wb("t5.idle", 1'b0, 5'd0, 32'd0);

        // 6: async reset with three queued entries
        p_valid = 1'b1; p_rd = 5'd7; p_data = 32'h77;
        m_valid = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            m_rd = 5'(r); m_data = 32'(r);
            tick();
        end
        m_valid = 1'b0;
        chk("t6.count3", {29'd0, fifo_count}, 32'd3);
        chk("t6.pending3", pending_mask, 32'h0000000E);
        chk("t6.we_before", {31'd0, wb_we}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6.we_async", {31'd0, wb_we}, 32'd0);
        chk("t6.count_rst", {29'd0, fifo_count}, 32'd0);
        chk("t6.pending_rst", pending_mask, 32'd0);
        chk("t6.stall_rst", {31'd0, stall_req}, 32'd0);
        chk("t6.m_ready_rst", {31'd0, m_ready}, 32'd0);
        p_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6.m_ready_rel", {31'd0, m_ready}, 32'd1);
        tick();
        chk("t6.no_stale1", {31'd0, wb_we}, 32'd0);
        chk("t6.count_rel", {29'd0, fifo_count}, 32'd0);
        tick();
        chk("t6.no_stale2", {31'd0, wb_we}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
